pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the MIPS datapath: holds the PC register and computes the next PC each cycle.
- Next PC is one of: sequential increment, PC-relative branch, absolute jump, call (jump plus push of the return address) or return (pop).
- Contains a small return-address stack (RAS).
- Feeds instruction-memory address and the fetch/decode flush logic.

Parameters:
- ADDR_W, 16, PC and address width in bits.
- STEP, 1, sequential increment (1 = word-addressed, 4 = byte-addressed).
- OFF_W, 8, width of the signed branch offset.
- RAS_DEPTH, 4, return-address stack entries (>=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold PC and RAS; all other controls ignored
- jump_i  in  1  load PC from tgt_i
- call_i  in  1  load PC from tgt_i; push PC+STEP
- ret_i  in  1  load PC from top of RAS; pop
- br_taken_i  in  1  load PC with PC + sext(br_off_i)
- br_off_i  in  OFF_W  signed branch offset, in address units
- tgt_i  in  ADDR_W  absolute jump/call target
- pc_o  out  ADDR_W  current PC (registered)
- pc_seq_o  out  ADDR_W  pc_o + STEP, combinational
- redirect_o  out  1  registered; high for one cycle after any non-sequential PC load
- ras_cnt_o  out  clog2(RAS_DEPTH+1)  valid RAS entries
- ras_ovf_o  out  1  sticky: push attempted while RAS full
- ras_unf_o  out  1  sticky: pop attempted while RAS empty

Behaviour:
- Reset, synchronous: pc_o=RESET_PC, redirect_o=0, ras_cnt_o=0, ras_ovf_o=0, ras_unf_o=0. RAS contents are don't-care.
- rst dominates stall_i and every control input. Reset mid-sequence discards all RAS state.
- Per-edge priority when not in reset:
  - stall_i: pc_o, RAS, count and flags hold; redirect_o <= 0.
  - jump_i: pc <= tgt_i.
  - call_i: pc <= tgt_i; push pc_seq_o.
  - ret_i: pop; pc <= top entry.
  - br_taken_i: pc <= pc_o + sext(br_off_i).
  - else: pc <= pc_seq_o.
- The highest-priority active control wins; lower controls are ignored with no side effects (e.g. jump_i with call_i asserted does not push).
- redirect_o <= 1 exactly when the selected source is jump, call, ret or branch. This includes a ret on an empty RAS.
- Arithmetic: all PC sums are modulo 2^ADDR_W; wrap is silent. The offset is sign-extended to ADDR_W before the add. Branch is relative to the current PC, not PC+STEP.
- RAS is a LIFO with registered count and a single push or pop per cycle. Push writes entry[cnt] and increments cnt; pop reads entry[cnt-1] and decrements cnt.
- Push when cnt==RAS_DEPTH:
  - entry not written, cnt unchanged;
  - ras_ovf_o <= 1;
  - PC still loads tgt_i.
- Pop when cnt==0:
  - cnt unchanged; ras_unf_o <= 1;
  - pc <= pc_seq_o (sequential fallback);
  - redirect_o still asserts.
- Sticky flags clear only on rst.
- Latency: control inputs take effect at the next clock edge. pc_seq_o has zero latency.

Decomposition:
- Shared package pc_pkg holds:
  - ADDR_W_DEF and RESET_PC_DEF constants;
  - the next-PC source enum (SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET, SRC_HOLD), also used by the hazard unit.
- One sub-module: ret_addr_stack, with parameters RAS_DEPTH and ADDR_W, ports push/pop/din/dout/cnt/full/empty.
- Next-PC mux, PC register and flags stay in pc_sequencer.

Test Plan:
- Reset, then 3 idle cycles (ADDR_W=16, STEP=1) -> pc_o = 0, 1, 2, 3; redirect_o stays 0.
- pc_o=0x0010, br_taken_i=1, br_off_i=8'hFC -> next pc_o=0x000C, redirect_o=1 for one cycle. pc_o=0xFFFF with no controls -> next pc_o=0x0000.
- pc_o=0x0020, call_i=1, tgt_i=0x0100 -> pc_o=0x0100, ras_cnt_o=1. Later ret_i=1 -> pc_o=0x0021, ras_cnt_o=0.
- 5 calls with RAS_DEPTH=4 -> ras_ovf_o=1 after the 5th, ras_cnt_o=4. 4 returns -> PCs return in LIFO order of the first 4 pushes. 5th ret -> pc_o=prev+1, ras_unf_o=1.
- stall_i=1 with jump_i=1, tgt_i=0x0200 -> pc_o unchanged, redirect_o=0. Same cycle with jump_i and call_i both high -> pc_o=tgt_i, ras_cnt_o unchanged.
- rst asserted mid-sequence with ras_cnt_o=2 and call_i=1 -> next cycle pc_o=RESET_PC, ras_cnt_o=0, flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit and the hazard logic.
// Lists the next-PC sources and the default address width and reset PC.
package pc_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_CALL,
        SRC_RET,
        SRC_HOLD
    } pc_src_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO. It performs one push or one pop per cycle.
// A push when full or a pop when empty is dropped here; the caller raises the flags.
module ret_addr_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int ADDR_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [ADDR_W-1:0]              din_i,
    output logic [ADDR_W-1:0]              dout_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] cnt_o,
    output logic                           full_o,
    output logic                           empty_o
);
    localparam int CNT_W = $clog2(RAS_DEPTH+1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;

    // The top entry is read combinationally. Its value is meaningless while the stack is empty.
    assign dout_o = mem_q[IDX_W'(cnt_q - 1'b1)];
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push)     cnt_d = cnt_q + 1'b1;
        else if (do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[IDX_W'(cnt_q)] <= din_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with next-PC selection: sequential, branch, jump, call and return.
// It also holds the sticky overflow and underflow flags for the return stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int STEP      = 1,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = RESET_PC_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall_i,
    input  logic                           jump_i,
    input  logic                           call_i,
    input  logic                           ret_i,
    input  logic                           br_taken_i,
    input  logic [OFF_W-1:0]               br_off_i,
    input  logic [ADDR_W-1:0]              tgt_i,
    output logic [ADDR_W-1:0]              pc_o,
    output logic [ADDR_W-1:0]              pc_seq_o,
    output logic                           redirect_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt_o,
    output logic                           ras_ovf_o,
    output logic                           ras_unf_o
);
    pc_src_e                  src;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     redir_q, redir_d;
    logic                     ovf_q, ovf_d, unf_q, unf_d;
    logic                     ras_push, ras_pop, ras_full, ras_empty;
    logic [ADDR_W-1:0]        ras_top;
    logic signed [OFF_W-1:0]  off_s;

    assign off_s    = br_off_i;
    assign pc_seq_o = pc_q + ADDR_W'(STEP);

    always_comb begin
        src = SRC_SEQ;
        if (stall_i)         src = SRC_HOLD;
        else if (jump_i)     src = SRC_JMP;
        else if (call_i)     src = SRC_CALL;
        else if (ret_i)      src = SRC_RET;
        else if (br_taken_i) src = SRC_BR;
    end

    assign ras_push = (src == SRC_CALL);
    assign ras_pop  = (src == SRC_RET);

    always_comb begin
        pc_d    = pc_seq_o;
        redir_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (src)
            SRC_HOLD: pc_d = pc_q;
            SRC_JMP: begin
                pc_d    = tgt_i;
                redir_d = 1'b1;
            end
            SRC_CALL: begin
                pc_d    = tgt_i;
                redir_d = 1'b1;
                ovf_d   = ovf_q | ras_full;
            end
            // A return on an empty stack falls through to sequential. It still counts as a redirect.
            SRC_RET: begin
                pc_d    = ras_empty ? pc_seq_o : ras_top;
                redir_d = 1'b1;
                unf_d   = unf_q | ras_empty;
            end
            SRC_BR: begin
                pc_d    = pc_q + ADDR_W'(off_s);
                redir_d = 1'b1;
            end
            default: pc_d = pc_seq_o;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= ADDR_W'(RESET_PC);
            redir_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ret_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .din_i   (pc_seq_o),
        .dout_o  (ras_top),
        .cnt_o   (ras_cnt_o),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign pc_o       = pc_q;
    assign redirect_o = redir_q;
    assign ras_ovf_o  = ovf_q;
    assign ras_unf_o  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus checked against a queue-based model of the PC unit.
module tb_pc_sequencer;
    localparam int ADDR_W = 16, STEP = 1, OFF_W = 8, DEPTH = 4, RST_PC = 0;
    localparam int MASK = (1 << ADDR_W) - 1;

    logic              clk = 1'b0, rst = 1'b1;
    logic              stall_i = 0, jump_i = 0, call_i = 0, ret_i = 0, br_taken_i = 0;
    logic [OFF_W-1:0]  br_off_i = '0;
    logic [ADDR_W-1:0] tgt_i = '0;
    logic [ADDR_W-1:0] pc_o, pc_seq_o;
    logic              redirect_o, ras_ovf_o, ras_unf_o;
    logic [2:0]        ras_cnt_o;

    int checks = 0, errors = 0;
    int m_pc = RST_PC, m_ovf = 0, m_unf = 0, m_red = 0;
    int m_ras[$];

    pc_sequencer #(.ADDR_W(ADDR_W), .STEP(STEP), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH),
                   .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .call_i(call_i),
        .ret_i(ret_i), .br_taken_i(br_taken_i), .br_off_i(br_off_i), .tgt_i(tgt_i),
        .pc_o(pc_o), .pc_seq_o(pc_seq_o), .redirect_o(redirect_o),
        .ras_cnt_o(ras_cnt_o), .ras_ovf_o(ras_ovf_o), .ras_unf_o(ras_unf_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", int'(pc_o), m_pc);
        chk("redirect", int'(redirect_o), m_red);
        chk("ras_cnt", int'(ras_cnt_o), m_ras.size());
        chk("ovf", int'(ras_ovf_o), m_ovf);
        chk("unf", int'(ras_unf_o), m_unf);
    endtask

    // Applies one cycle of controls. It then advances the model by one cycle and checks the DUT outputs after the edge.
    task automatic step(input bit r, input bit st, input bit j, input bit c, input bit rt,
                        input bit b, input logic [OFF_W-1:0] off, input int tgt);
        int nxt;
        rst = r; stall_i = st; jump_i = j; call_i = c; ret_i = rt; br_taken_i = b;
        br_off_i = off; tgt_i = tgt[ADDR_W-1:0];
        #1 chk("pc_seq", int'(pc_seq_o), (m_pc + STEP) & MASK);
        nxt = (m_pc + STEP) & MASK;
        m_red = 0;
        if (r) begin
            nxt = RST_PC; m_ras.delete(); m_ovf = 0; m_unf = 0;
        end else if (st) begin
            nxt = m_pc;
        end else if (j) begin
            nxt = tgt & MASK; m_red = 1;
        end else if (c) begin
            if (m_ras.size() < DEPTH) m_ras.push_back((m_pc + STEP) & MASK);
            else m_ovf = 1;
            nxt = tgt & MASK; m_red = 1;
        end else if (rt) begin
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else m_unf = 1;
            m_red = 1;
        end else if (b) begin
            nxt = (m_pc + int'($signed(off))) & MASK; m_red = 1;
        end
        m_pc = nxt;
        @(posedge clk);
        #1 check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, '0, 0);
        repeat (3) idle();

        // Backward branch, then wrap from 0xFFFF to zero
        step(0, 0, 1, 0, 0, 0, '0, 16'h0010);
        step(0, 0, 0, 0, 0, 1, 8'hFC, 0);
        idle();
        step(0, 0, 1, 0, 0, 0, '0, 16'hFFFF);
        idle();

        // Call followed by a return
        step(0, 0, 1, 0, 0, 0, '0, 16'h0020);
        step(0, 0, 0, 1, 0, 0, '0, 16'h0100);
        idle();
        step(0, 0, 0, 0, 1, 0, '0, 0);

        // Five calls overflow the stack; five returns then underflow it
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, '0, 16'h1000 + i * 16'h100);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, '0, 0);

        // A stall masks a jump; a jump has priority over a call
        step(0, 1, 1, 0, 0, 0, '0, 16'h0200);
        step(0, 0, 1, 1, 0, 0, '0, 16'h0200);

        // A reset mid-sequence with two entries on the stack and call_i asserted
        step(1, 0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 1, 0, 0, '0, 16'h0300);
        step(0, 0, 0, 1, 0, 0, '0, 16'h0400);
        step(1, 0, 0, 1, 0, 0, '0, 16'h0500);

        // Random controls, biased toward calls and returns so the stack runs to both ends
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            step((sel == 0), ($urandom_range(0, 7) == 0), (sel >= 1 && sel < 10),
                 (sel >= 10 && sel < 35), (sel >= 35 && sel < 60), ($urandom_range(0, 2) == 0),
                 OFF_W'($urandom), int'($urandom & MASK));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
